if_fetch_pair: RTL and testbench

Dual-issue instruction fetch stage feeding the IF→ID instruction queue. It owns the fetch PC, requests 64-bit aligned fetch blocks from the instruction cache over an addr_ok/data_ok handshake, and unpacks each block into one or two instruction lines. Each line carries its own valid flag, and line2 is only valid when line1 is valid. It redirects on branch or exception flush and discards any response that was in flight at the flush.

---
 rtl/if_fetch_pair.sv | 143 ++++++++++++++
 tb/tb_if_fetch_pair.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_pair.sv
// if_fetch_pair: dual-issue fetch stage, 64-bit block -> two IF/ID lines.
// Ports: clk, rst_n (async, active-high); branch/excep flush + target PC;
//   inst_req_o/inst_addr_o/inst_addr_ok_i/inst_data_ok_i/inst_rdata_i to
//   the I-cache; next_allowin_i, line1/line2 valids, to_next_obus to ID.
// Optional: IF_ADEF_CHECK_EN raises adef on misaligned PCs and stops.
module if_fetch_pair #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          branch_flush_i,
  input  logic [31:0]   branch_pc_i,
  input  logic          excep_flush_i,
  input  logic [31:0]   excep_pc_i,
  output logic          inst_req_o,
  output logic [31:0]   inst_addr_o,
  input  logic          inst_addr_ok_i,
  input  logic          inst_data_ok_i,
  input  logic [63:0]   inst_rdata_i,
  input  logic          next_allowin_i,
  output logic          line1_to_next_valid_o,
  output logic          line2_to_next_valid_o,
  output logic [129:0]  to_next_obus
);

  localparam logic [2:0] S_REQ    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_CANCEL = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] pc_step;
  logic [31:0] target;
  logic [31:0] tgt_load;
  logic [31:0] rst_pc;
  logic        flush;
  logic        adef;
  logic        req_fire;
  logic        transfer;
  logic        l1_v;
  logic        l2_v;
  logic [64:0] l1;
  logic [64:0] l2;

  assign flush  = excep_flush_i | branch_flush_i;
  assign target = excep_flush_i ? excep_pc_i : branch_pc_i;

`ifdef IF_ADEF_CHECK_EN
  assign tgt_load = target;
  assign rst_pc   = RESET_PC;
  assign adef     = fetch_pc[1:0] != 2'b00;
`else
  assign tgt_load = {target[31:2], 2'b00};
  assign rst_pc   = {RESET_PC[31:2], 2'b00};
  assign adef     = 1'b0;
`endif

  assign req_fire = (state == S_REQ) & ~adef;
  assign transfer = (state == S_HOLD) & next_allowin_i;
  assign pc_step  = fetch_pc[2] ? 32'd4 : 32'd8;

  assign inst_req_o  = req_fire;
  assign inst_addr_o = {fetch_pc[31:3], 3'b000};

  // The flush cycle never hands lines downstream.
  assign line1_to_next_valid_o = l1_v & ~flush;
  assign line2_to_next_valid_o = l2_v & ~flush;
  assign to_next_obus = {l2, l1};

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // A response still owed by the cache must be swallowed.
      if ((state == S_WAIT && !inst_data_ok_i) ||
          (state == S_CANCEL && !inst_data_ok_i) ||
          (req_fire && inst_addr_ok_i))
        state_nxt = S_CANCEL;
      else
        state_nxt = S_REQ;
    end else begin
      unique case (state)
        S_REQ: begin
          if (adef)
            state_nxt = S_HOLD;
          else if (inst_addr_ok_i)
            state_nxt = S_WAIT;
        end
        S_WAIT:
          if (inst_data_ok_i) state_nxt = S_HOLD;
        S_HOLD:
          if (next_allowin_i) state_nxt = l1[64] ? S_STOP : S_REQ;
        S_CANCEL:
          if (inst_data_ok_i) state_nxt = S_REQ;
        S_STOP:
          state_nxt = S_STOP;
        default:
          state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S_REQ;
      fetch_pc <= rst_pc;
      l1_v     <= 1'b0;
      l2_v     <= 1'b0;
      l1       <= '0;
      l2       <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        fetch_pc <= tgt_load;
        l1_v     <= 1'b0;
        l2_v     <= 1'b0;
      end else if (transfer) begin
        fetch_pc <= fetch_pc + pc_step;
        l1_v     <= 1'b0;
        l2_v     <= 1'b0;
      end else if (state == S_WAIT && inst_data_ok_i) begin
        l1_v <= 1'b1;
        if (fetch_pc[2]) begin
          l1   <= {1'b0, fetch_pc, inst_rdata_i[63:32]};
          l2   <= '0;
          l2_v <= 1'b0;
        end else begin
          l1   <= {1'b0, fetch_pc, inst_rdata_i[31:0]};
          l2   <= {1'b0, fetch_pc + 32'd4, inst_rdata_i[63:32]};
          l2_v <= 1'b1;
        end
      end else if (state == S_REQ && adef) begin
        l1   <= {1'b1, fetch_pc, 32'h0};
        l1_v <= 1'b1;
        l2   <= '0;
        l2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_pair.sv
// tb_if_fetch_pair: directed + random bench for if_fetch_pair against a
// transaction-level fetch model (outstanding/stale/held/stopped flags).
module tb_if_fetch_pair;

  localparam logic [31:0] RPC = 32'h1C00_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          bf, ef, aok, dok, alw;
  logic [31:0]   bpc, epc;
  logic [63:0]   rd;
  logic          req;
  logic [31:0]   addr;
  logic          v1, v2;
  logic [129:0]  bus;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [63:0] m_data;
  logic        m_busy, m_stale, m_have, m_stop, m_adef;

  always #5 clk = ~clk;

  if_fetch_pair #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst),
    .branch_flush_i(bf), .branch_pc_i(bpc),
    .excep_flush_i(ef), .excep_pc_i(epc),
    .inst_req_o(req), .inst_addr_o(addr),
    .inst_addr_ok_i(aok), .inst_data_ok_i(dok),
    .inst_rdata_i(rd), .next_allowin_i(alw),
    .line1_to_next_valid_o(v1), .line2_to_next_valid_o(v2),
    .to_next_obus(bus)
  );

  task automatic check(input string tag,
                       input logic [129:0] got,
                       input logic [129:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [129:0] exp_bus();
    if (m_adef)
      return {65'b0, 1'b1, m_pc, 32'h0};
    if (!m_pc[2])
      return {1'b0, m_pc + 32'd4, m_data[63:32],
              1'b0, m_pc, m_data[31:0]};
    return {65'b0, 1'b0, m_pc, m_data[63:32]};
  endfunction

  function automatic logic can_req();
    logic r;
    r = !m_busy && !m_have && !m_stop;
`ifdef IF_ADEF_CHECK_EN
    r = r && (m_pc[1:0] == 2'b00);
`endif
    return r;
  endfunction

  // Entered at a negedge: drive, check, advance model, wait a cycle.
  task automatic step(input logic fb_i, input logic [31:0] bpc_i,
                      input logic fe_i, input logic [31:0] epc_i,
                      input logic aok_i, input logic dok_i,
                      input logic [63:0] rd_i, input logic alw_i);
    logic fl, mreq;
    logic [31:0] tgt;
    bf = fb_i; bpc = bpc_i; ef = fe_i; epc = epc_i;
    aok = aok_i; dok = dok_i; rd = rd_i; alw = alw_i;
    #1;
    fl   = fb_i | fe_i;
    tgt  = fe_i ? epc_i : bpc_i;
    mreq = can_req();
    check("req", {129'b0, req}, {129'b0, mreq});
    check("addr", {98'b0, addr}, {98'b0, m_pc[31:3], 3'b000});
    check("v1", {129'b0, v1}, {129'b0, m_have && !fl});
    check("v2", {129'b0, v2},
          {129'b0, m_have && !fl && !m_adef && !m_pc[2]});
    if (m_have) check("bus", bus, exp_bus());
    if (fl) begin
`ifdef IF_ADEF_CHECK_EN
      m_pc = tgt;
`else
      m_pc = {tgt[31:2], 2'b00};
`endif
      m_have = 0; m_stop = 0; m_adef = 0;
      if (m_busy && !dok_i) m_stale = 1;
      else if (mreq && aok_i) begin m_busy = 1; m_stale = 1; end
      else begin m_busy = 0; m_stale = 0; end
    end else if (mreq && aok_i) begin
      m_busy = 1; m_stale = 0;
    end else if (m_busy && dok_i) begin
      m_busy = 0;
      if (!m_stale) begin m_have = 1; m_data = rd_i; end
      m_stale = 0;
    end else if (m_have && alw_i) begin
      m_have = 0;
      if (m_adef) begin m_adef = 0; m_stop = 1; end
      else m_pc = m_pc + (m_pc[2] ? 32'd4 : 32'd8);
    end else if (!m_busy && !m_have && !m_stop &&
                 m_pc[1:0] != 2'b00) begin
      m_have = 1; m_adef = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic alw_i);
    step(0, 0, 0, 0, 0, 0, 64'h0, alw_i);
  endtask

  initial begin
    logic [31:0] t;
    logic fl, e;
    rst = 1; bf = 0; ef = 0; aok = 0; dok = 0; alw = 0;
    bpc = 0; epc = 0; rd = 0;
    m_pc = RPC; m_data = 0;
    m_busy = 0; m_stale = 0; m_have = 0; m_stop = 0; m_adef = 0;
    repeat (2) @(negedge clk);
    check("rst_req", {129'b0, req}, {129'b0, 1'b1});
    check("rst_addr", {98'b0, addr}, {98'b0, RPC});
    check("rst_v1", {129'b0, v1}, 130'b0);
    check("rst_v2", {129'b0, v2}, 130'b0);
    check("rst_bus", bus, 130'b0);
    rst = 0;

    // first block, both lines
    step(0, 0, 0, 0, 1, 0, 64'h0, 1);
    step(0, 0, 0, 0, 0, 1, 64'h22222222_11111111, 1);
    step(0, 0, 0, 0, 0, 0, 64'h0, 1);
    check("t1_addr", {98'b0, addr}, {98'b0, 32'h1C00_0008});

    // branch to upper word: single line
    step(1, 32'h1C00_0104, 0, 0, 0, 0, 64'h0, 0);
    step(0, 0, 0, 0, 1, 0, 64'h0, 0);
    step(0, 0, 0, 0, 0, 1, 64'hBBBBBBBB_AAAAAAAA, 0);
    step(0, 0, 0, 0, 0, 0, 64'h0, 1);
    check("t2_addr", {98'b0, addr}, {98'b0, 32'h1C00_0108});

    // downstream back-pressure
    step(0, 0, 0, 0, 1, 0, 64'h0, 0);
    step(0, 0, 0, 0, 0, 1, 64'h44444444_33333333, 0);
    repeat (5) idle(0);
    idle(1);

    // flush in WAIT, stale response two cycles later
    step(0, 0, 0, 0, 1, 0, 64'h0, 0);
    step(1, 32'h1C00_0200, 0, 0, 0, 0, 64'h0, 0);
    idle(0);
    step(0, 0, 0, 0, 0, 1, 64'hDEADDEAD_DEADDEAD, 1);
    step(0, 0, 0, 0, 1, 0, 64'h0, 1);
    step(0, 0, 0, 0, 0, 1, 64'h66666666_55555555, 1);
    idle(1);

    // exception beats branch
    step(1, 32'h1C00_0300, 1, 32'h1C00_1000, 0, 0, 64'h0, 0);
    check("t5_addr", {98'b0, addr}, {98'b0, 32'h1C00_1000});

`ifdef IF_ADEF_CHECK_EN
    step(1, 32'h1C00_0002, 0, 0, 0, 0, 64'h0, 0);
    idle(0);
    idle(1);
    repeat (3) idle(1);
    step(0, 0, 1, 32'h1C00_0000, 0, 0, 64'h0, 0);
    idle(0);
`endif

    for (int i = 0; i < 4000; i++) begin
      fl = ($urandom_range(0, 15) == 0);
      e  = fl && $urandom_range(0, 1);
      t  = RPC | ($urandom & 32'hFFF);
      if ($urandom_range(0, 31) == 0)
        t = 32'hFFFF_FFF8 | ($urandom & 32'h7);
      if (!can_req() && !m_busy && !m_have && !m_stop)
        t = t & ~32'h3;
      step(fl && !e ? 1'b1 : ($urandom_range(0, 3) == 0 && fl),
           e ? ($urandom | 32'h0) : t,
           e, t,
           can_req() && $urandom_range(0, 1),
           m_busy ? ($urandom_range(0, 2) == 0)
                  : ($urandom_range(0, 19) == 0),
           {$urandom, $urandom},
           $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
